// File: rtl/bus_arbiter_rr.sv
// Round-robin system bus arbiter with begin-timeout and stalled-transaction watchdogs.
// Define ARBITER_PRIORITY_EN to give master 0 strict priority over the round-robin group.
module bus_arbiter_rr #(
    parameter int NR_MASTERS      = 4,
    parameter int BEGIN_TIMEOUT   = 15,
    parameter int WATCHDOG_CYCLES = 1023
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NR_MASTERS-1:0]         request,
    output logic [NR_MASTERS-1:0]         grants,
    input  logic                          begin_transaction_in,
    input  logic                          end_transaction_in,
    input  logic                          data_valid_in,
    output logic                          end_transaction_out,
    output logic                          bus_error_out,
    output logic [$clog2(NR_MASTERS)-1:0] active_master,
    output logic                          bus_idle
);

    localparam int MW = $clog2(NR_MASTERS);
    localparam int BW = $clog2(BEGIN_TIMEOUT + 1);
    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [BW-1:0] BEGIN_LAST = BW'(BEGIN_TIMEOUT - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(WATCHDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANTED,
        TRANSACTION,
        ERROR,
        RELEASE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [BW-1:0]   bcnt;
    logic [WW-1:0]   wcnt;
    logic [MW-1:0]   last;
    logic [MW-1:0]   win;
    logic [NR_MASTERS-1:0] win_oh;
    logic            found;
    logic            owner_req;

    always_comb begin
        int idx;
        idx    = 0;
        win    = '0;
        win_oh = '0;
        found  = 1'b0;
`ifdef ARBITER_PRIORITY_EN
        if (request[0]) begin
            found = 1'b1;
        end else begin
            // rotate over masters 1..N-1 only, starting after the pointer
            for (int i = 1; i < NR_MASTERS; i++) begin
                idx = ((int'(last) - 1 + i + (NR_MASTERS - 1))
                       % (NR_MASTERS - 1)) + 1;
                if (!found && request[idx]) begin
                    found = 1'b1;
                    win   = MW'(idx);
                end
            end
        end
`else
        for (int i = 1; i <= NR_MASTERS; i++) begin
            idx = (int'(last) + i) % NR_MASTERS;
            if (!found && request[idx]) begin
                found = 1'b1;
                win   = MW'(idx);
            end
        end
`endif
        if (found) begin
            win_oh[win] = 1'b1;
        end
    end

    assign owner_req = |(request & grants);
    assign bus_idle  = (state == IDLE);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (found) state_next = GRANTED;
            end
            GRANTED: begin
                if (begin_transaction_in)  state_next = TRANSACTION;
                else if (!owner_req)       state_next = RELEASE;
                else if (bcnt == BEGIN_LAST) state_next = RELEASE;
            end
            TRANSACTION: begin
                if (end_transaction_in) state_next = RELEASE;
                else if (!data_valid_in && wcnt == WD_LAST)
                    state_next = ERROR;
            end
            ERROR:   state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            bcnt                <= '0;
            wcnt                <= '0;
            last                <= MW'(NR_MASTERS - 1);
            grants              <= '0;
            active_master       <= '0;
            end_transaction_out <= 1'b0;
            bus_error_out       <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                bcnt <= '0;
                wcnt <= '0;
            end else if (state == GRANTED) begin
                if (bcnt != '1) bcnt <= bcnt + BW'(1);
            end else if (state == TRANSACTION) begin
                if (data_valid_in)   wcnt <= '0;
                else if (wcnt != '1) wcnt <= wcnt + WW'(1);
            end
            if (state == IDLE && found) begin
                grants        <= win_oh;
                active_master <= win;
`ifdef ARBITER_PRIORITY_EN
                if (win != '0) last <= win;
`else
                last <= win;
`endif
            end else if (state_next == RELEASE) begin
                grants <= '0;
            end
            bus_error_out       <= (state_next == ERROR);
            end_transaction_out <= (state_next == ERROR);
        end
    end

endmodule
